// File: rtl/mux_3_1_hls_deadlock_pkg.sv
// Shared types and record layout for the mux_3_1 HLS deadlock monitor and report unit.
package mux_3_1_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WATCH  = 2'd1,
    ST_REPORT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int DEF_NUM_AXIS = 4;
  localparam int DEF_TS_WIDTH = 28;
  // Report record is {channel_mask, timestamp}; the mask sits above the timestamp.
  localparam int MASK_LSB     = DEF_TS_WIDTH;

endpackage

// File: rtl/mux_3_1_hls_deadlock_report_unit_if.sv
// Report record channel from the deadlock report unit to its consumer.
interface mux_3_1_hls_deadlock_report_unit_if
  import mux_3_1_hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS = DEF_NUM_AXIS,
  parameter int TS_WIDTH = DEF_TS_WIDTH
);
  // A record transfers on every rising edge where report_valid and report_ready are both
  // high; once valid rises, it and report_data hold until that edge, and ready may lead valid.
  logic                         report_valid;
  logic                         report_ready;
  logic [NUM_AXIS+TS_WIDTH-1:0] report_data;

  modport master (output report_valid, output report_data, input report_ready);
  modport slave  (input report_valid, input report_data, output report_ready);
endinterface

// File: rtl/mux_3_1_hls_deadlock_persist_cnt.sv
// Consecutive-high counter that saturates at THRESHOLD; hit flags the increment reaching it.
module mux_3_1_hls_deadlock_persist_cnt #(
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             hit
);
  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_plus;

  assign count_plus = count_q + 1'b1;
  // hit looks at the post-increment value so the caller can act on the same edge.
  assign hit        = inc && !clr && (count_plus == THR_C);
  assign count      = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != THR_C)) begin
      count_q <= count_plus;
    end
  end
endmodule

// File: rtl/mux_3_1_hls_deadlock_report_unit.sv
// Filters the deadlock monitor's block flag for persistence and emits one report per episode.
module mux_3_1_hls_deadlock_report_unit
  import mux_3_1_hls_deadlock_pkg::*;
#(
  parameter int NUM_AXIS  = DEF_NUM_AXIS,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 8,
  parameter int TS_WIDTH  = DEF_TS_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  mux_3_1_hls_deadlock_report_unit_if.master rpt,
  output logic                deadlock_detected,
  output logic [7:0]          report_count,
  output state_t              state_dbg,
  output logic [CNT_W-1:0]    persist_dbg
);

  if (THRESHOLD < 1 || THRESHOLD >= (1 << CNT_W)) begin : g_bad_threshold
    $error("THRESHOLD must lie in 1 .. 2**CNT_W-1");
  end

  state_t                       state_q, state_nxt;
  logic [TS_WIDTH-1:0]          ts_q;
  logic [NUM_AXIS-1:0]          mask_q, mask_nxt;
  logic [NUM_AXIS+TS_WIDTH-1:0] data_q;
  logic                         valid_q, det_q;
  logic [7:0]                   count_q;
  logic                         cnt_inc, cnt_clr, cnt_hit, accept;

  mux_3_1_hls_deadlock_persist_cnt #(
    .THRESHOLD (THRESHOLD),
    .CNT_W     (CNT_W)
  ) u_persist (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (persist_dbg),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:   if (block_in) state_nxt = cnt_hit ? ST_REPORT : ST_WATCH;
      ST_WATCH: begin
        if (clear || !block_in) state_nxt = ST_IDLE;
        else if (cnt_hit)       state_nxt = ST_REPORT;
      end
      ST_REPORT: if (rpt.report_ready) state_nxt = ST_HOLD;
      ST_HOLD:   if (clear) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath controls; REPORT deliberately ignores block_in and clear so a record is never lost.
  always_comb begin
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    accept   = 1'b0;
    mask_nxt = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_inc  = block_in;
        mask_nxt = block_in ? axis_block_sigs : '0;
      end
      ST_WATCH: begin
        if (clear || !block_in) begin
          cnt_clr  = 1'b1;
          mask_nxt = '0;
        end else begin
          cnt_inc  = 1'b1;
          mask_nxt = mask_q | axis_block_sigs;
        end
      end
      ST_REPORT: accept = rpt.report_ready;
      ST_HOLD: begin
        if (clear) begin
          cnt_clr  = 1'b1;
          mask_nxt = '0;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q    <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      det_q   <= 1'b0;
      count_q <= '0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      mask_q  <= mask_nxt;
      valid_q <= (state_nxt == ST_REPORT);
      det_q   <= (state_nxt == ST_REPORT) || (state_nxt == ST_HOLD);
      if (cnt_hit)                      data_q  <= {mask_nxt, ts_q};
      if (accept && (count_q != 8'hFF)) count_q <= count_q + 1'b1;
    end
  end

  assign rpt.report_valid  = valid_q;
  assign rpt.report_data   = data_q;
  assign deadlock_detected = det_q;
  assign report_count      = count_q;
  assign state_dbg         = state_q;
endmodule
